vector_mem_sequencer: RTL

- Sequences vector memory instructions (strv/ldrv) over the 32-bit data-memory port: one LANES*WORD_W vector is moved as LANES word beats at consecutive word addresses.
- Sits in the memory stage beside the scalar path; its memory outputs feed the data-memory mux selected by MemSrc.
- Stalls the pipeline until the transfer completes, then returns the assembled load vector.

---
 rtl/vector_mem_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer
//   Moves one LANES*WORD_W vector between the pipeline and the 32-bit data
//   memory. The vector travels as LANES word beats at consecutive word
//   addresses. The sequencer stalls the upstream stages until the transfer
//   is done. For a load (ldrv) it then presents the assembled vector on RdVec.
//
// Ports
//   clk, rst   clock; synchronous active-high reset
//   Req        vector memory op present in stage (held while Stall=1)
//   ReqWrite   1 = strv, 0 = ldrv (sampled at accept)
//   BaseAddr   byte address, word-aligned on accept
//   WrVec      store vector (sampled at accept)
//   MemRD      memory read data, 1-cycle synchronous latency
//   MemAddr    beat byte address
//   MemWE      memory write enable
//   MemWD      memory write data
//   RdVec      assembled load vector (lane 0 = lowest address)
//   Stall      freeze stages upstream of and including memory
//   Busy       sequencer not idle
//   Done       one-cycle completion pulse
//
// Build option
//   VMS_BYTE_SWAP_EN  reverse the byte order inside each word on MemWD and on
//                     MemRD before capture (big-endian AES state layout).
//
// State | meaning
// IDLE  | waiting for Req; Stall follows Req combinationally; accepts on Req
// XFER  | one beat per cycle at base + beat*bytes; stores write, loads read
// LAST  | load only: capture the final lane from the read latency slot
// DONE  | Done pulse, Stall released; Req is ignored here

module vector_mem_sequencer #(
  parameter int WORD_W = 32,
  parameter int LANES  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    Req,
  input  logic                    ReqWrite,
  input  logic [ADDR_W-1:0]       BaseAddr,
  input  logic [LANES*WORD_W-1:0] WrVec,
  input  logic [WORD_W-1:0]       MemRD,
  output logic [ADDR_W-1:0]       MemAddr,
  output logic                    MemWE,
  output logic [WORD_W-1:0]       MemWD,
  output logic [LANES*WORD_W-1:0] RdVec,
  output logic                    Stall,
  output logic                    Busy,
  output logic                    Done
);

  localparam int BYTES      = WORD_W / 8;
  localparam int BYTE_SHIFT = $clog2(BYTES);
  localparam int BEAT_W     = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(LANES - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    LAST,
    DONE
  } stateT;

  stateT                   state, stateNext;
  logic [BEAT_W-1:0]       beat, beatNext;
  logic                    isWrite;
  logic [ADDR_W-1:0]       base;
  logic [LANES*WORD_W-1:0] wrData;
  logic [LANES*WORD_W-1:0] rdData;

  logic                    accept;
  logic                    capEn;
  logic [BEAT_W-1:0]       capLane;
  logic [WORD_W-1:0]       wrWord;
  logic [WORD_W-1:0]       rdWord;

  function automatic logic [WORD_W-1:0] orderBytes(input logic [WORD_W-1:0] w);
`ifdef VMS_BYTE_SWAP_EN
    orderBytes = '0;
    for (int i = 0; i < BYTES; i++) begin
      orderBytes[i*8 +: 8] = w[(BYTES-1-i)*8 +: 8];
    end
`else
    orderBytes = w;
`endif
  endfunction

  assign wrWord = wrData[int'(beat)*WORD_W +: WORD_W];
  assign rdWord = orderBytes(MemRD);
  assign RdVec  = rdData;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      state <= stateNext;
      beat  <= beatNext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      isWrite <= 1'b0;
      base    <= '0;
      wrData  <= '0;
      rdData  <= '0;
    end else begin
      if (accept) begin
        isWrite <= ReqWrite;
        base    <= BaseAddr & ALIGN_MASK;
        wrData  <= WrVec;
      end
      if (capEn) begin
        for (int i = 0; i < LANES; i++) begin
          if (capLane == BEAT_W'(i)) begin
            rdData[i*WORD_W +: WORD_W] <= rdWord;
          end
        end
      end
    end
  end

  always_comb begin
    stateNext = state;
    beatNext  = beat;
    accept    = 1'b0;
    capEn     = 1'b0;
    capLane   = LAST_BEAT;
    MemAddr   = '0;
    MemWE     = 1'b0;
    MemWD     = '0;
    Stall     = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;

    case (state)
      IDLE: begin
        Stall = Req;
        if (Req) begin
          accept    = 1'b1;
          beatNext  = '0;
          stateNext = XFER;
        end
      end

      XFER: begin
        Busy    = 1'b1;
        Stall   = 1'b1;
        // The address wraps modulo 2^ADDR_W. This is allowed and is not flagged.
        MemAddr = base + (ADDR_W'(beat) << BYTE_SHIFT);
        if (isWrite) begin
          MemWE = 1'b1;
          MemWD = orderBytes(wrWord);
        end else if (beat != '0) begin
          // Read data for the previous beat arrives in this cycle.
          capEn   = 1'b1;
          capLane = beat - BEAT_W'(1);
        end
        beatNext = beat + BEAT_W'(1);
        if (beat == LAST_BEAT) begin
          beatNext  = '0;
          stateNext = isWrite ? DONE : LAST;
        end
      end

      LAST: begin
        Busy      = 1'b1;
        Stall     = 1'b1;
        capEn     = 1'b1;
        capLane   = LAST_BEAT;
        stateNext = DONE;
      end

      DONE: begin
        Busy      = 1'b1;
        Done      = 1'b1;
        stateNext = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule
